// File: rtl/dma_controller.sv
// Single-channel memory-to-memory DMA engine driving a shared tri-state bus after arbitration.
// Optional cycle-steal mode (release bus between units) is enabled by DMA_CYCLE_STEAL_EN.
module dma_controller #(
  parameter int unsigned ADDR_BUS_WIDTH = 32,
  parameter int unsigned DATA_BUS_WIDTH = 8,
  parameter int unsigned COUNT_WIDTH    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [ADDR_BUS_WIDTH-1:0] src_addr,
  input  logic [ADDR_BUS_WIDTH-1:0] dst_addr,
  input  logic [COUNT_WIDTH-1:0]    count,
  output logic                      busy,
  output logic                      done,
  output logic                      dma_req,
  input  logic                      dma_grant,
  inout  wire  [ADDR_BUS_WIDTH-1:0] addr_bus,
  inout  wire  [DATA_BUS_WIDTH-1:0] data_bus,
  inout  wire                       wr_bus,
  inout  wire                       rd_bus,
  input  logic                      fc_bus
);

  typedef enum logic [2:0] {
    StIdle, StReq, StRead, StRrel, StWrite, StWrel, StYield, StDone
  } state_e;

  state_e                    state_q, state_d;
  logic [ADDR_BUS_WIDTH-1:0] src_q, dst_q;
  logic [COUNT_WIDTH-1:0]    cnt_q;
  logic [DATA_BUS_WIDTH-1:0] buf_q;

  logic drive, src_phase, wr_phase;

  // Bus ownership is gated by the live grant so a dropped grant releases the bus at once.
  always_comb begin
    src_phase = (state_q == StRead)  || (state_q == StRrel);
    wr_phase  = (state_q == StWrite) || (state_q == StWrel);
    drive     = dma_grant && (src_phase || wr_phase);
  end

  assign addr_bus = drive ? (src_phase ? src_q : dst_q) : {ADDR_BUS_WIDTH{1'bz}};
  assign data_bus = (drive && wr_phase) ? buf_q : {DATA_BUS_WIDTH{1'bz}};
  assign rd_bus   = drive ? (state_q == StRead)  : 1'bz;
  assign wr_bus   = drive ? (state_q == StWrite) : 1'bz;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = (count != '0) ? StReq : StDone;
      StReq:   if (dma_grant) state_d = StRead;
      StRead:  if (dma_grant && fc_bus) state_d = StRrel;
      StRrel:  if (dma_grant && !fc_bus) state_d = StWrite;
      StWrite: if (dma_grant && fc_bus) state_d = StWrel;
      StWrel: begin
        if (dma_grant && !fc_bus) begin
          if (cnt_q == COUNT_WIDTH'(1)) begin
            state_d = StDone;
          end else begin
`ifdef DMA_CYCLE_STEAL_EN
            state_d = StYield;
`else
            state_d = StRead;
`endif
          end
        end
      end
      StYield: state_d = StReq;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      buf_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      dma_req <= 1'b0;
    end else begin
      state_q <= state_d;
      // Outputs are registered from the next state so they line up with state_q.
      busy    <= (state_d != StIdle);
      done    <= (state_d == StDone);
      dma_req <= (state_d == StReq) || (state_d == StRead) || (state_d == StRrel) ||
                 (state_d == StWrite) || (state_d == StWrel);
      if (state_q == StIdle && start && count != '0) begin
        src_q <= src_addr;
        dst_q <= dst_addr;
        cnt_q <= count;
      end
      if (state_q == StRead && state_d == StRrel) begin
        buf_q <= data_bus;
      end
      if (state_q == StWrel && state_d != StWrel) begin
        src_q <= src_q + ADDR_BUS_WIDTH'(1);
        dst_q <= dst_q + ADDR_BUS_WIDTH'(1);
        if (cnt_q != '0) cnt_q <= cnt_q - COUNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_dma_controller.sv
// Self-checking bench for dma_controller: combinational 1-cycle slave, simple CPU/DMA arbiter
// model and a scoreboard of expected bus reads and writes.
module tb_dma_controller;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 8;
  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] src_addr = '0;
  logic [AW-1:0] dst_addr = '0;
  logic [CW-1:0] count = '0;
  logic          busy, done, dma_req, dma_grant, fc_bus;
  wire  [AW-1:0] addr_bus;
  wire  [DW-1:0] data_bus;
  wire           wr_bus, rd_bus;

  logic grant_en = 1'b1;
  logic cpu_req = 1'b0;
  logic cpu_gnt_q;

  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;
  logic [AW-1:0]    exp_rd[$];
  logic [AW+DW-1:0] exp_wr[$];

  // Undriven strobes float high; both high therefore means nobody drives the bus.
  pullup (rd_bus);
  pullup (wr_bus);

  wire slave_rd = rd_bus & ~wr_bus;
  wire slave_wr = wr_bus & ~rd_bus;

  function automatic logic [DW-1:0] src_byte(input logic [AW-1:0] a);
    return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h3C;
  endfunction

  assign fc_bus    = slave_rd | slave_wr;
  assign data_bus  = slave_rd ? src_byte(addr_bus) : {DW{1'bz}};
  assign dma_grant = grant_en & dma_req & ~cpu_gnt_q;

  // CPU takes a free bus for one cycle, then gives the DMA its turn.
  always @(posedge clk or negedge rst) begin
    if (!rst) cpu_gnt_q <= 1'b0;
    else      cpu_gnt_q <= cpu_req && !dma_req && !cpu_gnt_q;
  end

  always #5 clk = ~clk;

  dma_controller #(
    .ADDR_BUS_WIDTH(AW),
    .DATA_BUS_WIDTH(DW),
    .COUNT_WIDTH   (CW)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .count    (count),
    .busy     (busy),
    .done     (done),
    .dma_req  (dma_req),
    .dma_grant(dma_grant),
    .addr_bus (addr_bus),
    .data_bus (data_bus),
    .wr_bus   (wr_bus),
    .rd_bus   (rd_bus),
    .fc_bus   (fc_bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard consumer: every bus read/write the slave sees must match the next expectation.
  always @(negedge clk) begin
    if (rst) begin
      if (slave_rd) begin
        if (exp_rd.size() == 0) check("rd_extra", 32'd1, 32'd0);
        else check("rd_addr", addr_bus, exp_rd.pop_front());
      end
      if (slave_wr) begin
        if (exp_wr.size() == 0) begin
          check("wr_extra", 32'd1, 32'd0);
        end else begin
          logic [AW+DW-1:0] e;
          e = exp_wr.pop_front();
          check("wr_addr", addr_bus, e[AW+DW-1:DW]);
          check("wr_data", 32'(data_bus), 32'(e[DW-1:0]));
        end
      end
      if (done) done_cnt++;
    end
  end

  task automatic kick(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [CW-1:0] n,
                      input bit push);
    @(negedge clk);
    src_addr = s;
    dst_addr = d;
    count    = n;
    start    = 1'b1;
    if (push) begin
      for (int i = 0; i < int'(n); i++) begin
        exp_rd.push_back(s + AW'(i));
        exp_wr.push_back({d + AW'(i), src_byte(s + AW'(i))});
      end
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_wait(input int max_cyc, output int cyc, output int gaps, output int cpu_gr);
    bit seen;
    seen = 1'b0; cyc = 0; gaps = 0; cpu_gr = 0;
    while (!seen && cyc < max_cyc) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        seen = 1'b1;
      end else begin
        if (busy && !dma_req) gaps++;
        if (busy && cpu_gnt_q) cpu_gr++;
      end
    end
    check("done_seen", 32'(seen), 32'd1);
  endtask

  task automatic check_idle(input string tag, input int exp_done);
    @(negedge clk);
    check({tag, "_done_low"}, 32'(done), 32'd0);
    check({tag, "_busy_low"}, 32'(busy), 32'd0);
    check({tag, "_req_low"}, 32'(dma_req), 32'd0);
    check({tag, "_done_cnt"}, 32'(done_cnt), 32'(exp_done));
    check({tag, "_sb_empty"}, 32'(exp_rd.size() + exp_wr.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, gaps, cpu_gr, exp_cyc, exp_gaps, exp_cpu, d0;
    bit found;
`ifdef DMA_CYCLE_STEAL_EN
    exp_cyc = 17; exp_gaps = 2;
`else
    exp_cyc = 13; exp_gaps = 0;
`endif

    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_req", 32'(dma_req), 32'd0);
    check("rst_strobes_z", 32'({rd_bus, wr_bus}), 32'd3);
    rst = 1'b1;
    @(negedge clk);

    // Basic three-unit copy.
    kick(32'h100, 32'h200, 16'd3, 1'b1);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_req", 32'(dma_req), 32'd1);
    run_wait(100, cyc, gaps, cpu_gr);
    check("t1_cycles", 32'(cyc), 32'(exp_cyc));
    check("t1_gaps", 32'(gaps), 32'(exp_gaps));
    check_idle("t1", 1);

    // Zero-length transfer: immediate done, no bus activity.
    kick(32'h500, 32'h600, 16'd0, 1'b0);
    check("t2_done", 32'(done), 32'd1);
    check("t2_req", 32'(dma_req), 32'd0);
    check("t2_strobes_z", 32'({rd_bus, wr_bus}), 32'd3);
    check_idle("t2", 2);

    // Grant withheld: DMA waits in REQ without touching the bus.
    grant_en = 1'b0;
    kick(32'h120, 32'h220, 16'd2, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t3_req_hold", 32'(dma_req), 32'd1);
      check("t3_strobes_z", 32'({rd_bus, wr_bus}), 32'd3);
    end
    grant_en = 1'b1;
    @(negedge clk);
    check("t3_rd_first", 32'({rd_bus, wr_bus}), 32'd2);
    run_wait(100, cyc, gaps, cpu_gr);
    check_idle("t3", 3);

    // Competing CPU: burst keeps the bus, cycle-steal yields once between units.
`ifdef DMA_CYCLE_STEAL_EN
    exp_gaps = 1; exp_cpu = 1;
`else
    exp_gaps = 0; exp_cpu = 0;
`endif
    cpu_req = 1'b1;
    kick(32'h140, 32'h240, 16'd2, 1'b1);
    run_wait(100, cyc, gaps, cpu_gr);
    check("t4_req_gaps", 32'(gaps), 32'(exp_gaps));
    check("t4_cpu_grants", 32'(cpu_gr), 32'(exp_cpu));
    cpu_req = 1'b0;
    check_idle("t4", 4);

    // Reset during WRITE aborts silently; restart then wraps the source address.
    kick(32'hFFFF_FFFF, 32'h300, 16'd2, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (slave_wr) found = 1'b1;
    end
    check("t5_reach_write", 32'(found), 32'd1);
    #1 rst = 1'b0;
    #1;
    check("t5_abort_req", 32'(dma_req), 32'd0);
    check("t5_abort_busy", 32'(busy), 32'd0);
    check("t5_abort_strobes_z", 32'({rd_bus, wr_bus}), 32'd3);
    exp_rd.delete();
    exp_wr.delete();
    d0 = done_cnt;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t5_no_done", 32'(done_cnt), 32'(d0));
    kick(32'hFFFF_FFFF, 32'h300, 16'd2, 1'b1);
    run_wait(100, cyc, gaps, cpu_gr);
    check_idle("t5", d0 + 1);

    // Start while busy is ignored.
    kick(32'h10, 32'h40, 16'd3, 1'b1);
    repeat (3) @(negedge clk);
    src_addr = 32'h80;
    dst_addr = 32'h90;
    count    = 16'd5;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    run_wait(100, cyc, gaps, cpu_gr);
    check_idle("t6", d0 + 2);
    repeat (3) @(negedge clk);
    check("t6_stays_idle", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
